// File: rtl/deser_pack_if.sv
// Beat-side and word-side req/ack signals of the deserialiser/packer.
// The DUT takes the slave view; the producer/consumer environment takes the master view.
interface deser_pack_if #(
    parameter int dw = 8,
    parameter int K  = 4,
    parameter int CW = 3
);
    logic [dw-1:0]   d_in;
    logic            last_in;
    logic            req_in;
    logic            ack_in;
    logic [K*dw-1:0] d_out;
    logic [CW-1:0]   nb_out;
    logic            last_out;
    logic            req_out;
    logic            ack_out;

    modport slave (
        input  d_in, last_in, req_in, ack_out,
        output ack_in, d_out, nb_out, last_out, req_out
    );

    modport master (
        output d_in, last_in, req_in, ack_out,
        input  ack_in, d_out, nb_out, last_out, req_out
    );
endinterface

// File: rtl/deser_pack.sv
// Packs K narrow beats into one wide word; last_in flushes a partial word early.
// The packed word sits in a registered req/ack output stage with same-cycle drain and refill.
module deser_pack #(
    parameter int dw = 8,
    parameter int K  = 4,
    parameter int CW = 3
) (
    input  logic         clk,
    input  logic         rstn,
    deser_pack_if.slave  bus
);
    localparam int CNTW = (K > 2) ? $clog2(K) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(K - 1);

    logic [CNTW-1:0] cnt_q;
    logic [K*dw-1:0] buf_q;
    logic [K*dw-1:0] buf_d;
    logic [K*dw-1:0] word_d;
    logic [K*dw-1:0] d_out_q;
    logic [CW-1:0]   nb_out_q;
    logic            last_out_q;
    logic            req_out_q;
    logic            completing;
    logic            ack_in;
    logic            beat_acc;

    // A completing beat needs the output register free (or draining this cycle).
    always_comb begin
        completing = (cnt_q == CNT_LAST) || bus.last_in;
        ack_in     = completing ? (~req_out_q | bus.ack_out) : 1'b1;
        beat_acc   = bus.req_in & ack_in;
        buf_d      = buf_q;
        word_d     = '0;
        for (int i = 0; i < K; i++) begin
            if (i < int'(cnt_q)) begin
                word_d[i*dw +: dw] = buf_q[i*dw +: dw];
            end else if (i == int'(cnt_q)) begin
                word_d[i*dw +: dw] = bus.d_in;
                buf_d[i*dw +: dw]  = bus.d_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            buf_q      <= '0;
            d_out_q    <= '0;
            nb_out_q   <= '0;
            last_out_q <= 1'b0;
            req_out_q  <= 1'b0;
        end else if (beat_acc && completing) begin
            d_out_q    <= word_d;
            nb_out_q   <= CW'(cnt_q) + CW'(1);
            last_out_q <= bus.last_in;
            req_out_q  <= 1'b1;
            cnt_q      <= '0;
            buf_q      <= '0;
        end else begin
            if (req_out_q && bus.ack_out) begin
                req_out_q <= 1'b0;
            end
            if (beat_acc) begin
                buf_q <= buf_d;
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

    assign bus.ack_in   = ack_in;
    assign bus.d_out    = d_out_q;
    assign bus.nb_out   = nb_out_q;
    assign bus.last_out = last_out_q;
    assign bus.req_out  = req_out_q;
endmodule
